// File: rtl/instr_mem_loader.sv
// Byte-stream boot loader: receives a 16-bit word count, little-endian 32-bit
// instruction words and an XOR checksum, and writes the words into instruction memory.
module instr_mem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [15:0]   count;
  logic [AW-1:0] idx;
  logic [1:0]    bcnt;
  logic [23:0]   asm_q;
  logic [7:0]    csum;

  logic          accept;
  logic [15:0]   hdr_count;
  logic          last_word;

  assign accept    = in_valid & in_ready;
  assign hdr_count = {in_data, count[7:0]};
  assign last_word = (16'(idx) == count - 16'd1);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      idx       <= '0;
      bcnt      <= '0;
      asm_q     <= '0;
      csum      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_HDR0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            bcnt     <= '0;
            csum     <= '0;
          end
        end
        S_HDR0: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept) begin
            count[15:8] <= in_data;
            if (hdr_count == 16'd0 || hdr_count > 16'(DEPTH)) begin
              state    <= S_ERROR;
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ in_data;
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                // Word goes straight to the output register, leaving asm_q
                // free so the next byte can be taken during the write cycle.
                mem_we    <= 1'b1;
                mem_addr  <= idx;
                mem_wdata <= {in_data, asm_q};
                if (last_word) state <= S_CHK;
                else           idx   <= idx + 1'b1;
              end
            endcase
          end
        end
        S_CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of load scenarios plus hand-written
// sequences for asynchronous reset, idle-byte rejection and mid-load reset.
module tb_instr_mem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [7:0]       hdr0;
    logic [7:0]       hdr1;
    int               ndata;
    logic [7:0][7:0]  data;
    bit               has_chk;
    logic [7:0]       chk;
    bit               gaps;
    bit               start_mid;
    int               exp_nw;
    logic [1:0][31:0] exp_w;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  localparam logic [7:0][7:0]  GOOD_DATA = {8'h00, 8'h10, 8'h00, 8'h93,
                                            8'h00, 8'h50, 8'h00, 8'h13};
  localparam logic [1:0][31:0] GOOD_W    = {32'h0010_0093, 32'h0050_0013};

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  vec_t vecs[6];

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      automatic logic rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      ok = (rdy === 1'b1);
    end
    in_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    we_cnt = 0;
    pulse_start();
    check({v.name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    check({v.name, "_ready_after_start"}, {31'd0, in_ready}, 32'd1);
    send_byte(v.hdr0, 0);
    send_byte(v.hdr1, 0);
    if (v.ndata == 0) check({v.name, "_err_after_hdr1"}, {31'd0, err}, 32'd1);
    for (int i = 0; i < v.ndata; i++) begin
      send_byte(v.data[i], v.gaps ? int'($urandom_range(0, 3)) : 0);
      if (i % 4 == 3) begin
        check({v.name, "_we"}, {31'd0, mem_we}, 32'd1);
        check({v.name, "_addr"}, 32'(mem_addr), 32'(i / 4));
        check({v.name, "_wdata"}, mem_wdata, v.exp_w[i / 4]);
      end
      if (v.start_mid && i == 1) begin
        pulse_start();
        check({v.name, "_busy_after_mid_start"}, {31'd0, busy}, 32'd1);
        check({v.name, "_ready_after_mid_start"}, {31'd0, in_ready}, 32'd1);
      end
    end
    if (v.has_chk) send_byte(v.chk, v.gaps ? 2 : 0);
    @(negedge clk);
    check({v.name, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
    check({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    check({v.name, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({v.name, "_ready_end"}, {31'd0, in_ready}, 32'd0);
    check({v.name, "_write_cycles"}, 32'(we_cnt), 32'(v.exp_nw));
    if (v.exp_nw > 0) begin
      check({v.name, "_addr_hold"}, 32'(mem_addr), 32'(v.exp_nw - 1));
      check({v.name, "_wdata_hold"}, mem_wdata, v.exp_w[v.exp_nw - 1]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"good", 8'h02, 8'h00, 8, GOOD_DATA, 1'b1, 8'hC0, 1'b0, 1'b0, 2, GOOD_W, 1'b1, 1'b0};
    vecs[1] = '{"badchk", 8'h02, 8'h00, 8, GOOD_DATA, 1'b1, 8'hC1, 1'b0, 1'b0, 2, GOOD_W, 1'b0, 1'b1};
    vecs[2] = '{"oversize", 8'h41, 8'h00, 0, GOOD_DATA, 1'b0, 8'h00, 1'b0, 1'b0, 0, GOOD_W, 1'b0, 1'b1};
    vecs[3] = '{"zero", 8'h00, 8'h00, 0, GOOD_DATA, 1'b0, 8'h00, 1'b0, 1'b0, 0, GOOD_W, 1'b0, 1'b1};
    vecs[4] = '{"gaps", 8'h02, 8'h00, 8, GOOD_DATA, 1'b1, 8'hC0, 1'b1, 1'b0, 2, GOOD_W, 1'b1, 1'b0};
    vecs[5] = '{"midstart", 8'h02, 8'h00, 8, GOOD_DATA, 1'b1, 8'hC0, 1'b0, 1'b1, 2, GOOD_W, 1'b1, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

    run_vec(vecs[0]);

    // Asynchronous reset mid-cycle with non-zero outputs pending.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 1; k < 6; k++) run_vec(vecs[k]);

    // Bytes offered while idle must not be taken.
    we_cnt   = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_writes", 32'(we_cnt), 32'd0);
    run_vec(vecs[0]);

    // Reset after two data bytes: nothing written, next load is clean.
    we_cnt = 0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_writes", 32'(we_cnt), 32'd0);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
